// File: rtl/fifo_stream_packetizer_pkg.sv
// rtl/fifo_stream_packetizer_pkg.sv - shared state type, header layout and header packing
// Purpose: types and constants shared by the packetizer top and its read buffer.
package fifo_stream_packetizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

    // Header word, MSB first: {magic, seq, payload length}, zero-extended to the bus.
    localparam int MAGIC_W   = 16;
    localparam int SEQ_W     = 32;
    localparam int LEN_W     = 16;
    localparam int HDR_W     = MAGIC_W + SEQ_W + LEN_W;
    localparam int LEN_LSB   = 0;
    localparam int SEQ_LSB   = LEN_LSB + LEN_W;
    localparam int MAGIC_LSB = SEQ_LSB + SEQ_W;

    localparam logic [MAGIC_W-1:0] MAGIC_DEFAULT = 16'hC0DE;

    function automatic logic [HDR_W-1:0] pack_header(
        input logic [MAGIC_W-1:0] magic,
        input logic [SEQ_W-1:0]   seq,
        input logic [LEN_W-1:0]   len
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[MAGIC_LSB +: MAGIC_W] = magic;
        h[SEQ_LSB +: SEQ_W]     = seq;
        h[LEN_LSB +: LEN_W]     = len;
        return h;
    endfunction

endpackage

// File: rtl/fifo_stream_packetizer_if.sv
// rtl/fifo_stream_packetizer_if.sv - FIFO read port and AXI-Stream master bundle
// Purpose: groups the FIFO read side and the outgoing stream of the packetizer.
// Ports (master = packetizer side):
//   fifo_re    out  read strobe to the FIFO
//   fifo_dout  in   FIFO data, valid the cycle after an accepted read
//   fifo_empty in   FIFO empty flag
//   m_tdata/m_tvalid/m_tlast out, m_tready in: outgoing stream
interface fifo_stream_packetizer_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  fifo_re;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        output fifo_re, m_tdata, m_tvalid, m_tlast,
        input  fifo_dout, fifo_empty, m_tready
    );

    modport slave (
        input  fifo_re, m_tdata, m_tvalid, m_tlast,
        output fifo_dout, fifo_empty, m_tready
    );
endinterface

// File: rtl/fifo_read_skid.sv
// rtl/fifo_read_skid.sv - FIFO read engine with in-flight flag and 2-entry buffer
// Purpose: hides the one-cycle FIFO read latency behind a valid/ready head.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   active_i        reads allowed (packetizer not idle)
//   fifo_re_o       read strobe to the FIFO
//   fifo_dout_i     FIFO data for the read accepted last cycle
//   fifo_empty_i    FIFO empty flag
//   head_valid_o/head_data_o/head_ready_i  buffer head toward the FSM
module fifo_read_skid #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active_i,
    output logic                  fifo_re_o,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                  fifo_empty_i,
    output logic                  head_valid_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    input  logic                  head_ready_i
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  inflight_q;

    logic       push;
    logic       pop;
    logic [1:0] committed;

    assign head_valid_o = (count_q != 2'd0);
    assign head_data_o  = mem_q[rd_ptr_q];
    assign pop          = head_valid_o && head_ready_i;
    assign push         = inflight_q;

    // Slots spoken for at the end of this cycle: the word leaving now frees
    // its slot, the word in flight claims one. Counting the pop lets a new
    // read go out every cycle while the head drains, so there is no bubble.
    assign committed = count_q - {1'b0, pop} + {1'b0, inflight_q};

    // Gated by rst so no read is accepted while the buffer is being cleared.
    assign fifo_re_o = rst && active_i && !fifo_empty_i && (committed < 2'd2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_re_o;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fifo_dout_i;
        end
    end

endmodule

// File: rtl/fifo_stream_packetizer.sv
// rtl/fifo_stream_packetizer.sv - drains the FIFO into fixed-length header+payload stream packets
// Purpose: emits {header, PAYLOAD_WORDS data words} packets, tlast on the final data word.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   en            packetizing enable, sampled only at packet boundaries
//   bus           FIFO read side and stream master (master modport)
//   seq_num       sequence number of the packet being sent or next to be sent
//   stall_cycles  saturating count of payload cycles with the sink ready but no data
module fifo_stream_packetizer
    import fifo_stream_packetizer_pkg::*;
#(
    parameter int              DATA_WIDTH    = 64,
    parameter int              PAYLOAD_WORDS = 1024,
    parameter logic [15:0]     MAGIC         = MAGIC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    fifo_stream_packetizer_if.master      bus,
    output logic [31:0]                   seq_num,
    output logic [31:0]                   stall_cycles
);

    localparam logic [LEN_W-1:0] LEN_FIELD = LEN_W'(PAYLOAD_WORDS);
    localparam logic [LEN_W-1:0] LAST_IDX  = LEN_W'(PAYLOAD_WORDS - 1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [31:0]        stall_q, stall_d;

    logic                  skid_valid;
    logic                  skid_ready;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  fifo_re;

    logic                  tvalid;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic [DATA_WIDTH-1:0] hdr;

    fifo_read_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .active_i     (state_q != ST_IDLE),
        .fifo_re_o    (fifo_re),
        .fifo_dout_i  (bus.fifo_dout),
        .fifo_empty_i (bus.fifo_empty),
        .head_valid_o (skid_valid),
        .head_data_o  (skid_data),
        .head_ready_i (skid_ready)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        stall_d    = stall_q;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        tdata      = '0;
        skid_ready = 1'b0;
        hdr        = '0;
        hdr[HDR_W-1:0] = pack_header(MAGIC, seq_q, LEN_FIELD);

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                // Header goes out regardless of FIFO level; the payload paces itself.
                tvalid = 1'b1;
                tdata  = hdr;
                if (bus.m_tready) begin
                    state_d = ST_PAY;
                    cnt_d   = '0;
                end
            end
            ST_PAY: begin
                tvalid     = skid_valid;
                tdata      = skid_valid ? skid_data : '0;
                tlast      = skid_valid && (cnt_q == LAST_IDX);
                skid_ready = bus.m_tready;
                if (skid_valid && bus.m_tready) begin
                    if (cnt_q == LAST_IDX) begin
                        seq_d   = seq_q + 32'd1;
                        cnt_d   = '0;
                        state_d = en ? ST_HDR : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (bus.m_tready && (stall_q != '1)) begin
                    stall_d = stall_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            stall_q <= stall_d;
        end
    end

    assign bus.fifo_re  = fifo_re;
    assign bus.m_tvalid = tvalid;
    assign bus.m_tlast  = tlast;
    assign bus.m_tdata  = tdata;
    assign seq_num      = seq_q;
    assign stall_cycles = stall_q;

endmodule
